segment_led_sched: RTL and testbench

Time-shares the two-digit segment display between N_SRC requesters, such as the LED count, frame rate and error code. Each valid source is granted the display for a fixed dwell period, in round-robin order, with a blanking gap between owners. The block drives the 8-bit count and the blank indication consumed by the segment decoder, and sits between the controller datapath and segment_led.

---
 rtl/segment_led_pkg.sv | 17 +
 rtl/segment_led_rr_arb.sv | 35 +++
 rtl/segment_led_sched.sv | 153 +++++++++++++++
 tb/tb_segment_led_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/segment_led_pkg.sv
// Shared types and helpers for the segment display scheduler.
package segment_led_pkg;

  localparam int unsigned SEG_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/segment_led_rr_arb.sv
// Combinational round-robin pick: first valid index strictly after last_idx,
// with last_idx itself considered only as the final candidate.
module segment_led_rr_arb
  import segment_led_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IDX_W = idx_w(N_SRC)
) (
  input  logic [N_SRC-1:0] valid,
  input  logic [IDX_W-1:0] last_idx,
  output logic             any_valid_c,
  output logic             other_valid_c,
  output logic [IDX_W-1:0] next_idx_c
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    next_idx_c = last_idx;
    found      = 1'b0;
    cand       = last_idx;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = IDX_W'((32'(last_idx) + k) % N_SRC);
      if (!found && valid[cand]) begin
        next_idx_c = cand;
        found      = 1'b1;
      end
    end
  end

  assign any_valid_c   = |valid;
  assign other_valid_c = |(valid & ~(N_SRC'(1) << last_idx));

endmodule

// File: rtl/segment_led_sched.sv
// Round-robin time-sharing of the segment display with dwell and blanking gap.
module segment_led_sched
  import segment_led_pkg::*;
#(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DWELL_TICKS = 1000,
  parameter int unsigned BLANK_TICKS = 100
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [N_SRC-1:0]              src_valid_in,
  input  logic [N_SRC*SEG_DATA_W-1:0]   src_data_in,
  output logic [N_SRC-1:0]              grant_out,
  output logic [idx_w(N_SRC)-1:0]       active_src_out,
  output logic [SEG_DATA_W-1:0]         count_out,
  output logic                          blank_out
);

  localparam int unsigned IDX_W    = idx_w(N_SRC);
  localparam int unsigned PRE_W    = idx_w(TICK_DIV);
  localparam int unsigned TCNT_MAX = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int unsigned TCNT_W   = idx_w(TCNT_MAX + 1);

  sched_state_t          state_q, state_d;
  logic [PRE_W-1:0]      presc_q;
  logic [TCNT_W-1:0]     tcnt_q;
  logic                  tick, dwell_done, gap_done, owner_valid;
  logic                  load_show_c, restart_c;
  logic                  any_valid_c, other_valid_c;
  logic [IDX_W-1:0]      pick_c;
  logic [SEG_DATA_W-1:0] data_arr [N_SRC];

  logic [N_SRC-1:0]      grant_d;
  logic [IDX_W-1:0]      active_d;
  logic [SEG_DATA_W-1:0] count_d;
  logic                  blank_d;

  for (genvar g = 0; g < N_SRC; g++) begin : g_data
    assign data_arr[g] = src_data_in[SEG_DATA_W*g +: SEG_DATA_W];
  end

  segment_led_rr_arb #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_arb (
    .valid         (src_valid_in),
    .last_idx      (active_src_out),
    .any_valid_c   (any_valid_c),
    .other_valid_c (other_valid_c),
    .next_idx_c    (pick_c)
  );

  assign tick        = (presc_q == PRE_W'(TICK_DIV - 1));
  assign dwell_done  = tick && (tcnt_q == TCNT_W'(DWELL_TICKS - 1));
  assign gap_done    = (BLANK_TICKS > 0) && tick && (tcnt_q == TCNT_W'(BLANK_TICKS - 1));
  assign owner_valid = src_valid_in[active_src_out];

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; a drop of the owner is handled exactly like dwell expiry.
  always_comb begin
    state_d     = state_q;
    load_show_c = 1'b0;
    restart_c   = 1'b0;
    case (state_q)
      IDLE: begin
        restart_c = 1'b1;
        if (any_valid_c) begin
          state_d     = SHOW;
          load_show_c = 1'b1;
        end
      end
      SHOW: begin
        if (!owner_valid || dwell_done) begin
          restart_c = 1'b1;
          if (other_valid_c) begin
            if (BLANK_TICKS == 0) load_show_c = 1'b1;
            else                  state_d     = GAP;
          end else if (!owner_valid) begin
            state_d = (BLANK_TICKS == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        if (gap_done) begin
          restart_c   = 1'b1;
          state_d     = any_valid_c ? SHOW : IDLE;
          load_show_c = any_valid_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    grant_d  = grant_out;
    active_d = active_src_out;
    count_d  = count_out;
    blank_d  = blank_out;
    if (load_show_c) begin
      grant_d  = N_SRC'(1) << pick_c;
      active_d = pick_c;
      count_d  = data_arr[pick_c];
      blank_d  = 1'b0;
    end else begin
      case (state_d)
        SHOW: begin
          count_d = data_arr[active_src_out];
          blank_d = 1'b0;
        end
        GAP: begin
          grant_d = '0;
          blank_d = 1'b1;
        end
        default: begin
          grant_d = '0;
          count_d = '0;
          blank_d = 1'b1;
        end
      endcase
    end
  end

  // Output registers and phase timers; timers restart on every transition.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_out      <= '0;
      active_src_out <= IDX_W'(N_SRC - 1);
      count_out      <= '0;
      blank_out      <= 1'b1;
      presc_q        <= '0;
      tcnt_q         <= '0;
    end else begin
      grant_out      <= grant_d;
      active_src_out <= active_d;
      count_out      <= count_d;
      blank_out      <= blank_d;
      if (restart_c) begin
        presc_q <= '0;
        tcnt_q  <= '0;
      end else if (tick) begin
        presc_q <= '0;
        tcnt_q  <= tcnt_q + TCNT_W'(1);
      end else begin
        presc_q <= presc_q + PRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_segment_led_sched.sv
// Directed scoreboard bench for segment_led_sched (dwell 12 cycles, gap 8 cycles).
module tb_segment_led_sched;
  import segment_led_pkg::*;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst, rst2;
  logic [N-1:0]   valid, valid2;
  logic [N*8-1:0] data, data2;
  logic [N-1:0]   grant, grant2;
  logic [1:0]     active, active2;
  logic [7:0]     count, count2;
  logic           blank, blank2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  segment_led_sched #(.N_SRC(N), .TICK_DIV(4), .DWELL_TICKS(3), .BLANK_TICKS(2)) dut (
    .clk_in(clk), .rst_in(rst), .src_valid_in(valid), .src_data_in(data),
    .grant_out(grant), .active_src_out(active), .count_out(count), .blank_out(blank)
  );

  segment_led_sched #(.N_SRC(N), .TICK_DIV(4), .DWELL_TICKS(3), .BLANK_TICKS(0)) dut_nogap (
    .clk_in(clk), .rst_in(rst2), .src_valid_in(valid2), .src_data_in(data2),
    .grant_out(grant2), .active_src_out(active2), .count_out(count2), .blank_out(blank2)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    valid = 4'b1111; valid2 = 4'b0000;
    data  = {8'd40, 8'd30, 8'd20, 8'd10};
    data2 = {8'h00, 8'h00, 8'hBB, 8'hAA};

    // Reset held for three cycles with every source requesting.
    push("rst_grant", 0); push("rst_count", 0); push("rst_blank", 1); push("rst_active", 3);
    cyc(3);
    pop_chk(32'(grant)); pop_chk(32'(count)); pop_chk(32'(blank)); pop_chk(32'(active));
    rst = 1'b0;
    push("first_grant", 4'b0001); push("first_count", 10); push("first_blank", 0);
    cyc(1);
    pop_chk(32'(grant)); pop_chk(32'(count)); pop_chk(32'(blank));

    // Round robin over 4'b1011.
    valid = 4'b1011;
    push("rr_src0_end", 4'b0001); push("rr_src0_cnt", 10);
    cyc(11);
    pop_chk(32'(grant)); pop_chk(32'(count));
    push("rr_gap_grant", 0); push("rr_gap_blank", 1); push("rr_gap_count", 10);
    cyc(1);
    pop_chk(32'(grant)); pop_chk(32'(blank)); pop_chk(32'(count));
    push("rr_gap_end_blank", 1);
    cyc(7);
    pop_chk(32'(blank));
    push("rr_src1_grant", 4'b0010); push("rr_src1_cnt", 20); push("rr_src1_blank", 0);
    cyc(1);
    pop_chk(32'(grant)); pop_chk(32'(count)); pop_chk(32'(blank));
    push("rr_src3_grant", 4'b1000); push("rr_src3_cnt", 40); push("rr_src3_active", 3);
    cyc(20);
    pop_chk(32'(grant)); pop_chk(32'(count)); pop_chk(32'(active));
    push("rr_wrap_grant", 4'b0001); push("rr_wrap_cnt", 10);
    cyc(20);
    pop_chk(32'(grant)); pop_chk(32'(count));

    // Single source keeps the display across several dwell periods.
    rst = 1'b1; valid = 4'b0100; data[23:16] = 8'h7B;
    cyc(1);
    rst = 1'b0;
    push("single_grant", 4'b0100); push("single_cnt", 8'h7B);
    cyc(1);
    pop_chk(32'(grant)); pop_chk(32'(count));
    for (int i = 0; i < 40; i++) begin
      push("single_blank", 0);
      cyc(1);
      pop_chk(32'(blank));
    end
    push("single_hold_grant", 4'b0100);
    pop_chk(32'(grant));
    data[23:16] = 8'h05;
    push("single_live_cnt", 8'h05);
    cyc(1);
    pop_chk(32'(count));

    // Early drop of the owner, then a gap into a newly valid source.
    data = {8'd40, 8'd30, 8'd20, 8'd10};
    rst = 1'b1; valid = 4'b0010;
    cyc(1);
    rst = 1'b0;
    push("drop_own_grant", 4'b0010);
    cyc(1);
    pop_chk(32'(grant));
    cyc(5);
    valid = 4'b0100;
    push("drop_grant", 0); push("drop_blank", 1); push("drop_count", 20);
    cyc(1);
    pop_chk(32'(grant)); pop_chk(32'(blank)); pop_chk(32'(count));
    push("drop_gap_blank", 1);
    cyc(7);
    pop_chk(32'(blank));
    push("drop_next_grant", 4'b0100); push("drop_next_cnt", 30);
    cyc(1);
    pop_chk(32'(grant)); pop_chk(32'(count));

    // Drop with nothing else requesting: gap, then idle.
    valid = 4'b0000;
    push("idle_gap_blank", 1);
    cyc(1);
    pop_chk(32'(blank));
    push("idle_grant", 0); push("idle_blank", 1); push("idle_count", 0);
    cyc(8);
    pop_chk(32'(grant)); pop_chk(32'(blank)); pop_chk(32'(count));
    valid = 4'b0001;
    push("idle_wake_grant", 4'b0001); push("idle_wake_cnt", 10);
    cyc(1);
    pop_chk(32'(grant)); pop_chk(32'(count));

    // Reset in the middle of a gap.
    valid = 4'b0000;
    cyc(4);
    rst = 1'b1; valid = 4'b1111;
    push("midgap_grant", 0); push("midgap_count", 0); push("midgap_blank", 1); push("midgap_active", 3);
    cyc(1);
    pop_chk(32'(grant)); pop_chk(32'(count)); pop_chk(32'(blank)); pop_chk(32'(active));
    rst = 1'b0;
    push("midgap_first", 4'b0001);
    cyc(1);
    pop_chk(32'(grant));

    // No blanking gap: direct alternation between two sources.
    valid2 = 4'b0011; rst2 = 1'b0;
    push("nogap_grant", 4'b0001); push("nogap_cnt", 8'hAA); push("nogap_blank0", 0);
    cyc(1);
    pop_chk(32'(grant2)); pop_chk(32'(count2)); pop_chk(32'(blank2));
    for (int i = 1; i <= 24; i++) begin
      push("nogap_blank", 0);
      if (i == 11) push("nogap_src0_end", 4'b0001);
      if (i == 12) push("nogap_src1", 4'b0010);
      if (i == 12) push("nogap_src1_cnt", 8'hBB);
      if (i == 24) push("nogap_src0_again", 4'b0001);
      cyc(1);
      pop_chk(32'(blank2));
      if (i == 11 || i == 24) pop_chk(32'(grant2));
      if (i == 12) begin
        pop_chk(32'(grant2));
        pop_chk(32'(count2));
      end
    end

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
